// File: rtl/divsqrt_arbiter_if.sv
// Signal bundle around divsqrt_arbiter: two requesters, one response
// channel and the link to a single divSqrtRecFN_small unit.
// The arbiter keeps a flat port list; environments use this bundle to
// hold and route the same signals. The master modport is the arbiter's
// view and the slave modport is the view of the surrounding logic.
interface divsqrt_arbiter_if #(
    parameter int EXP_WIDTH = 8,
    parameter int SIG_WIDTH = 24
);
    localparam int REC_W = EXP_WIDTH + SIG_WIDTH + 1;

    logic             req0_valid;
    logic             req0_ready;
    logic             req0_sqrt;
    logic [REC_W-1:0] req0_a;
    logic [REC_W-1:0] req0_b;
    logic [2:0]       req0_rm;

    logic             req1_valid;
    logic             req1_ready;
    logic             req1_sqrt;
    logic [REC_W-1:0] req1_a;
    logic [REC_W-1:0] req1_b;
    logic [2:0]       req1_rm;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [REC_W-1:0] rsp_data;
    logic [4:0]       rsp_flags;

    logic             du_in_ready;
    logic             du_in_valid;
    logic             du_sqrt;
    logic [REC_W-1:0] du_a;
    logic [REC_W-1:0] du_b;
    logic [2:0]       du_rm;
    logic             du_out_valid;
    logic [REC_W-1:0] du_out;
    logic [4:0]       du_flags;

    logic [31:0]      op_count;
    logic [31:0]      busy_cycles;

    modport master (
        input  req0_valid, req0_sqrt, req0_a, req0_b, req0_rm,
        output req0_ready,
        input  req1_valid, req1_sqrt, req1_a, req1_b, req1_rm,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_flags,
        input  rsp_ready,
        input  du_in_ready, du_out_valid, du_out, du_flags,
        output du_in_valid, du_sqrt, du_a, du_b, du_rm,
        output op_count, busy_cycles
    );

    modport slave (
        output req0_valid, req0_sqrt, req0_a, req0_b, req0_rm,
        input  req0_ready,
        output req1_valid, req1_sqrt, req1_a, req1_b, req1_rm,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_flags,
        output rsp_ready,
        output du_in_ready, du_out_valid, du_out, du_flags,
        input  du_in_valid, du_sqrt, du_a, du_b, du_rm,
        input  op_count, busy_cycles
    );
endinterface

// File: rtl/divsqrt_arbiter.sv
// divsqrt_arbiter: shares one divSqrtRecFN_small unit between two
// requesters with round-robin arbitration and a single outstanding
// operation. Optional statistics counters are enabled by defining
// DIVSQRT_ARB_STATS_EN; otherwise op_count_o/busy_cycles_o read zero.
module divsqrt_arbiter #(
    parameter int  EXP_WIDTH = 8,
    parameter int  SIG_WIDTH = 24,
    localparam int REC_W     = EXP_WIDTH + SIG_WIDTH + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic             req0_sqrt_i,
    input  logic [REC_W-1:0] req0_a_i,
    input  logic [REC_W-1:0] req0_b_i,
    input  logic [2:0]       req0_rm_i,

    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic             req1_sqrt_i,
    input  logic [REC_W-1:0] req1_a_i,
    input  logic [REC_W-1:0] req1_b_i,
    input  logic [2:0]       req1_rm_i,

    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output logic [REC_W-1:0] rsp_data_o,
    output logic [4:0]       rsp_flags_o,

    input  logic             du_in_ready_i,
    output logic             du_in_valid_o,
    output logic             du_sqrt_o,
    output logic [REC_W-1:0] du_a_o,
    output logic [REC_W-1:0] du_b_o,
    output logic [2:0]       du_rm_o,
    input  logic             du_out_valid_i,
    input  logic [REC_W-1:0] du_out_i,
    input  logic [4:0]       du_flags_i,

    output logic [31:0]      op_count_o,
    output logic [31:0]      busy_cycles_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    state_t           state_reg;
    state_t           state_next;

    // Requester signals gathered into indexable form.
    logic [1:0]       req_valid;
    logic [1:0]       req_sqrt;
    logic [REC_W-1:0] req_a [2];
    logic [REC_W-1:0] req_b [2];
    logic [2:0]       req_rm [2];
    logic [1:0]       req_ready;

    logic             gnt_valid;
    logic             gnt_id;
    logic             start;
    logic             issue_fire;
    logic             capture;
    logic             resp_fire;

    logic             last_id_reg;
    logic             id_reg;
    logic             sqrt_reg;
    logic [REC_W-1:0] a_reg;
    logic [REC_W-1:0] b_reg;
    logic [2:0]       rm_reg;
    logic             du_in_valid_reg;
    logic             rsp_valid_reg;
    logic [REC_W-1:0] data_reg;
    logic [4:0]       flags_reg;

    assign req_valid = {req1_valid_i, req0_valid_i};
    assign req_sqrt  = {req1_sqrt_i, req0_sqrt_i};
    assign req_a[0]  = req0_a_i;
    assign req_a[1]  = req1_a_i;
    assign req_b[0]  = req0_b_i;
    assign req_b[1]  = req1_b_i;
    assign req_rm[0] = req0_rm_i;
    assign req_rm[1] = req1_rm_i;

    // Round-robin pick: on contention serve the requester not served last.
    always_comb begin
        gnt_valid = |req_valid;
        gnt_id    = 1'b0;
        if (&req_valid) begin
            gnt_id = ~last_id_reg;
        end else begin
            gnt_id = req_valid[1];
        end
    end

    assign start      = (state_reg == IDLE) && du_in_ready_i && gnt_valid;
    assign issue_fire = (state_reg == ISSUE) && du_in_ready_i;
    assign capture    = (state_reg == BUSY) && du_out_valid_i;
    assign resp_fire  = (state_reg == RESP) && rsp_ready_i;

    // Ready is only offered to the granted requester, and never during reset.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = rst_ni && start && (gnt_id == 1'(gi));
        end
    endgenerate

    assign req0_ready_o = req_ready[0];
    assign req1_ready_o = req_ready[1];

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: one operation in flight, no grant outside IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)      state_next = ISSUE;
            ISSUE:   if (issue_fire) state_next = BUSY;
            BUSY:    if (capture)    state_next = RESP;
            RESP:    if (resp_fire)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the granted request and drive the unit until it accepts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_reg          <= 1'b0;
            sqrt_reg        <= 1'b0;
            a_reg           <= '0;
            b_reg           <= '0;
            rm_reg          <= '0;
            du_in_valid_reg <= 1'b0;
        end else if (start) begin
            id_reg          <= gnt_id;
            sqrt_reg        <= req_sqrt[gnt_id];
            a_reg           <= req_a[gnt_id];
            b_reg           <= req_b[gnt_id];
            rm_reg          <= req_rm[gnt_id];
            du_in_valid_reg <= 1'b1;
        end else if (issue_fire) begin
            du_in_valid_reg <= 1'b0;
        end
    end

    // Result buffer: only a completion seen in BUSY is taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_reg      <= '0;
            flags_reg     <= '0;
            rsp_valid_reg <= 1'b0;
        end else if (capture) begin
            data_reg      <= du_out_i;
            flags_reg     <= du_flags_i;
            rsp_valid_reg <= 1'b1;
        end else if (resp_fire) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    // Last-served pointer moves only when a response is delivered;
    // reset points at requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_id_reg <= 1'b1;
        end else if (resp_fire) begin
            last_id_reg <= id_reg;
        end
    end

    assign du_in_valid_o = du_in_valid_reg;
    assign du_sqrt_o     = sqrt_reg;
    assign du_a_o        = a_reg;
    assign du_b_o        = b_reg;
    assign du_rm_o       = rm_reg;
    assign rsp_valid_o   = rsp_valid_reg;
    assign rsp_id_o      = id_reg;
    assign rsp_data_o    = data_reg;
    assign rsp_flags_o   = flags_reg;

`ifdef DIVSQRT_ARB_STATS_EN
    logic [31:0] op_count_reg;
    logic [31:0] busy_cycles_reg;

    // Count delivered responses and cycles the unit is occupied.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_count_reg    <= '0;
            busy_cycles_reg <= '0;
        end else begin
            if (resp_fire) begin
                op_count_reg <= op_count_reg + 32'd1;
            end
            if ((state_reg == ISSUE) || (state_reg == BUSY)) begin
                busy_cycles_reg <= busy_cycles_reg + 32'd1;
            end
        end
    end

    assign op_count_o    = op_count_reg;
    assign busy_cycles_o = busy_cycles_reg;
`else
    assign op_count_o    = 32'd0;
    assign busy_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_divsqrt_arbiter.sv
// Directed bench for divsqrt_arbiter. The bench plays the divider unit
// itself, returning known IEEE results recoded to the HardFloat format.
module tb_divsqrt_arbiter;
    localparam int REC_W = 33;
`ifdef DIVSQRT_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_ni;
    int   checks = 0;
    int   failures = 0;
    int   exp_ops = 0;
    int   exp_busy = 0;

    divsqrt_arbiter_if #(.EXP_WIDTH(8), .SIG_WIDTH(24)) bus ();

    divsqrt_arbiter #(.EXP_WIDTH(8), .SIG_WIDTH(24)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req0_valid_i(bus.req0_valid), .req0_ready_o(bus.req0_ready),
        .req0_sqrt_i(bus.req0_sqrt), .req0_a_i(bus.req0_a), .req0_b_i(bus.req0_b),
        .req0_rm_i(bus.req0_rm),
        .req1_valid_i(bus.req1_valid), .req1_ready_o(bus.req1_ready),
        .req1_sqrt_i(bus.req1_sqrt), .req1_a_i(bus.req1_a), .req1_b_i(bus.req1_b),
        .req1_rm_i(bus.req1_rm),
        .rsp_valid_o(bus.rsp_valid), .rsp_ready_i(bus.rsp_ready), .rsp_id_o(bus.rsp_id),
        .rsp_data_o(bus.rsp_data), .rsp_flags_o(bus.rsp_flags),
        .du_in_ready_i(bus.du_in_ready), .du_in_valid_o(bus.du_in_valid),
        .du_sqrt_o(bus.du_sqrt), .du_a_o(bus.du_a), .du_b_o(bus.du_b), .du_rm_o(bus.du_rm),
        .du_out_valid_i(bus.du_out_valid), .du_out_i(bus.du_out), .du_flags_i(bus.du_flags),
        .op_count_o(bus.op_count), .busy_cycles_o(bus.busy_cycles)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    // IEEE binary32 to 33-bit recoded form (finite values only).
    function automatic logic [32:0] recode(input logic [31:0] f);
        logic [7:0]  e;
        logic [22:0] fr;
        logic [22:0] sub;
        logic [8:0]  adj;
        int          lz;
        logic        found;
        e = f[30:23];
        fr = f[22:0];
        lz = 0;
        found = 1'b0;
        for (int i = 22; i >= 0; i--) begin
            if (!found) begin
                if (fr[i]) found = 1'b1;
                else lz++;
            end
        end
        if (e == 8'd0) begin
            sub = fr << (lz + 1);
            adj = (9'(lz) ^ 9'h1ff) + 9'd130;
        end else begin
            sub = fr;
            adj = {1'b0, e} + 9'd129;
        end
        if (e == 8'd0 && fr == 23'd0) adj[8:6] = 3'b000;
        return {f[31], adj, sub};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_op_count"}, bus.op_count, STATS ? 64'(exp_ops) : 64'd0);
        check({tag, "_busy_cycles"}, bus.busy_cycles, STATS ? 64'(exp_busy) : 64'd0);
    endtask

    // Act as the divider: called at the negedge right after a grant.
    task automatic du_serve(input string tag, input logic [32:0] ea, input logic [32:0] eb,
                            input logic esq, input logic [2:0] erm, input logic [32:0] res,
                            input logic [4:0] flg, input int lat, input int stall);
        for (int i = 0; i < stall; i++) begin
            bus.du_in_ready = 1'b0;
            #1;
            check({tag, "_issue_hold"}, bus.du_in_valid, 1);
            check({tag, "_issue_a_stable"}, bus.du_a, ea);
            exp_busy++;
            tick();
        end
        bus.du_in_ready = 1'b1;
        #1;
        check({tag, "_du_in_valid"}, bus.du_in_valid, 1);
        check({tag, "_du_a"}, bus.du_a, ea);
        check({tag, "_du_b"}, bus.du_b, eb);
        check({tag, "_du_sqrt"}, bus.du_sqrt, esq);
        check({tag, "_du_rm"}, bus.du_rm, erm);
        exp_busy++;
        tick();
        check({tag, "_du_in_valid_drop"}, bus.du_in_valid, 0);
        for (int i = 0; i < lat; i++) begin
            exp_busy++;
            tick();
        end
        bus.du_out_valid = 1'b1;
        bus.du_out = res;
        bus.du_flags = flg;
        exp_busy++;
        tick();
        bus.du_out_valid = 1'b0;
        bus.du_out = '1;
        bus.du_flags = '1;
    endtask

    // Expect a response now; rsp_ready must already be high.
    task automatic rsp_check(input string tag, input logic eid, input logic [32:0] edata,
                             input logic [4:0] eflags);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 1);
        check({tag, "_rsp_id"}, bus.rsp_id, eid);
        check({tag, "_rsp_data"}, bus.rsp_data, edata);
        check({tag, "_rsp_flags"}, bus.rsp_flags, eflags);
        check({tag, "_no_grant"}, {bus.req1_ready, bus.req0_ready}, 0);
        tick();
        exp_ops++;
        check({tag, "_rsp_one_cycle"}, bus.rsp_valid, 0);
    endtask

    logic [32:0] r0a, r0b, r1a, r1b, r0res, r1res, sqa, sqres;
    logic        id;

    initial begin
        r0a = recode(32'hc2140000);   r0b = recode(32'h418c0000);   r0res = recode(32'hc0075075);
        r1a = recode(32'hc4b0c000);   r1b = recode(32'hc64d2c00);   r1res = recode(32'h3ddc897c);
        sqa = recode(32'h40800000);   sqres = recode(32'h40000000);

        bus.req0_valid = 1'b1; bus.req0_sqrt = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_rm = '0;
        bus.req1_valid = 1'b0; bus.req1_sqrt = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_rm = '0;
        bus.rsp_ready = 1'b1; bus.du_in_ready = 1'b1; bus.du_out_valid = 1'b0;
        bus.du_out = '0; bus.du_flags = '0;
        rst_ni = 1'b0;
        tick(); tick(); #1;

        // Reset state, with req0 asking during reset.
        check("reset_req0_ready", bus.req0_ready, 0);
        check("reset_du_in_valid", bus.du_in_valid, 0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_data", bus.rsp_data, 0);
        check("reset_rsp_flags", bus.rsp_flags, 0);
        check("reset_du_a", bus.du_a, 0);
        check_stats("reset");
        bus.req0_valid = 1'b0;
        rst_ni = 1'b1;
        tick();

        // Both requesters at once: req0 first after reset, then req1.
        bus.req0_a = r0a; bus.req0_b = r0b;
        bus.req1_a = r1a; bus.req1_b = r1b;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        check("rr_first_req0_ready", bus.req0_ready, 1);
        check("rr_first_req1_ready", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 1'b0;
        du_serve("rr0", r0a, r0b, 1'b0, 3'd0, r0res, 5'h01, 4, 0);
        rsp_check("rr0", 1'b0, r0res, 5'h01);
        check("rr_next_req1_ready", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 1'b0;
        du_serve("rr1", r1a, r1b, 1'b0, 3'd0, r1res, 5'h01, 2, 1);
        rsp_check("rr1", 1'b1, r1res, 5'h01);

        // Subnormal divide with a 10-cycle response stall; req1 waits throughout.
        bus.req0_a = recode(32'h804d2c00); bus.req0_b = recode(32'h8009ec00);
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.rsp_ready = 1'b0;
        #1;
        check("sub_req0_ready", bus.req0_ready, 1);
        check("sub_req1_ready", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 1'b0;
        du_serve("sub", recode(32'h804d2c00), recode(32'h8009ec00), 1'b0, 3'd0,
                 recode(32'h40f8e4fd), 5'h01, 3, 0);
        for (int i = 0; i < 10; i++) begin
            check("sub_hold_valid", bus.rsp_valid, 1);
            check("sub_hold_id", bus.rsp_id, 0);
            check("sub_hold_data", bus.rsp_data, recode(32'h40f8e4fd));
            check("sub_hold_req1_ready", bus.req1_ready, 0);
            check("sub_hold_du_in_valid", bus.du_in_valid, 0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        rsp_check("sub", 1'b0, recode(32'h40f8e4fd), 5'h01);
        check("sub_next_req1_ready", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 1'b0;
        du_serve("rr1b", r1a, r1b, 1'b0, 3'd0, r1res, 5'h01, 1, 0);
        rsp_check("rr1b", 1'b1, r1res, 5'h01);

        // req0 alone: 12 / 3 with the unit briefly not ready.
        bus.req0_a = recode(32'h41400000); bus.req0_b = recode(32'h40400000);
        bus.req0_valid = 1'b1;
        #1;
        check("div12_req0_ready", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        du_serve("div12", recode(32'h41400000), recode(32'h40400000), 1'b0, 3'd0,
                 recode(32'h40800000), 5'h00, 3, 2);
        rsp_check("div12", 1'b0, recode(32'h40800000), 5'h00);
        check_stats("mid");

        // Spurious completion while idle must be ignored.
        bus.du_out_valid = 1'b1; bus.du_out = recode(32'h3f800000); bus.du_flags = 5'h1f;
        tick();
        bus.du_out_valid = 1'b0;
        check("spur_rsp_valid", bus.rsp_valid, 0);
        check("spur_rsp_data", bus.rsp_data, recode(32'h40800000));
        check("spur_rsp_flags", bus.rsp_flags, 0);
        check("spur_du_in_valid", bus.du_in_valid, 0);
        check_stats("spur");

        // Reset while BUSY: operation dropped, no response afterwards.
        bus.req0_valid = 1'b1;
        #1;
        check("abort_req0_ready", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        tick();
        check("abort_in_busy", bus.du_in_valid, 0);
        rst_ni = 1'b0;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        check("abort_rst_req0_ready", bus.req0_ready, 0);
        check("abort_rst_req1_ready", bus.req1_ready, 0);
        check("abort_rst_rsp_data", bus.rsp_data, 0);
        check("abort_rst_du_a", bus.du_a, 0);
        exp_ops = 0; exp_busy = 0;
        check_stats("abort_rst");
        tick(); tick();
        rst_ni = 1'b1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.du_out_valid = 1'b1; bus.du_out = recode(32'h40800000); bus.du_flags = 5'h00;
        tick();
        bus.du_out_valid = 1'b0;
        check("abort_no_rsp", bus.rsp_valid, 0);
        check("abort_no_issue", bus.du_in_valid, 0);
        tick();
        check("abort_no_rsp_late", bus.rsp_valid, 0);

        // Four back-to-back operations, both requesters always asking.
        bus.req0_a = r0a; bus.req0_b = r0b; bus.req0_sqrt = 1'b0; bus.req0_rm = 3'd0;
        bus.req1_a = sqa; bus.req1_b = '0; bus.req1_sqrt = 1'b1; bus.req1_rm = 3'd2;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            id = (k % 2) == 1;
            #1;
            check("b2b_req0_ready", bus.req0_ready, !id);
            check("b2b_req1_ready", bus.req1_ready, id);
            tick();
            if (id) begin
                du_serve("b2b_sqrt", sqa, 33'd0, 1'b1, 3'd2, sqres, 5'h00, k, 0);
                if (k == 3) begin
                    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
                end
                rsp_check("b2b_sqrt", 1'b1, sqres, 5'h00);
            end else begin
                du_serve("b2b_div", r0a, r0b, 1'b0, 3'd0, r0res, 5'h01, k + 1, 0);
                rsp_check("b2b_div", 1'b0, r0res, 5'h01);
            end
        end
        check("b2b_idle_after", bus.du_in_valid, 0);
        check_stats("b2b");

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
